// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS-subset control FSM with memory handshake and watchdog (CTRL_MUL_EN adds op 011100)
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               PCSrc,
  output logic               RegA,
  output logic               RegB,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Illegal,
  output logic               Fault
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, TRAP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_MUL  = 6'b011100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  state_t     state, nxt;
  logic [7:0] wd_cnt;
  logic [5:0] op_q, func_q;
  logic       illegal_q, fault_q;
  logic       r_ok, mul_ok, wait_st, timeout, shift;
  logic [3:0] r_code, alu;

  assign r_ok = (op == OP_R) &&
    (func inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010});
`ifdef CTRL_MUL_EN
  assign mul_ok = (op == OP_MUL) && (func inside {6'b100001, 6'b100000, 6'b000010});
`else
  assign mul_ok = 1'b0;
`endif
  assign wait_st = state inside {FETCH, MEM_RD, MEM_WR};
  assign timeout = wait_st && !MemReady && (wd_cnt == 8'(MEM_TIMEOUT));

  // state, watchdog, latched opcode and sticky error flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= FETCH;
      wd_cnt    <= 8'd0;
      op_q      <= 6'd0;
      func_q    <= 6'd0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= nxt;
      wd_cnt    <= (nxt != state) ? 8'd0 : wait_st ? wd_cnt + 8'd1 : wd_cnt;
      op_q      <= (state == DECODE) ? op : op_q;
      func_q    <= (state == DECODE) ? func : func_q;
      illegal_q <= illegal_q | ((state == DECODE) && (nxt == TRAP));
      fault_q   <= fault_q | timeout;
    end
  end

  // next-state sequencing; a memory handshake always beats the watchdog
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = MemReady ? DECODE : timeout ? TRAP : FETCH;
      DECODE:   nxt = (r_ok || mul_ok) ? EXEC_R :
                      (op == OP_ADDI || op == OP_ORI) ? EXEC_I :
                      (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                      (op == OP_BNE) ? BRANCH : TRAP;
      EXEC_R:   nxt = ALU_WB;
      EXEC_I:   nxt = ALU_WB;
      MEM_ADDR: nxt = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = MemReady ? MEM_WB : timeout ? TRAP : MEM_RD;
      MEM_WR:   nxt = MemReady ? FETCH : timeout ? TRAP : MEM_WR;
      MEM_WB:   nxt = FETCH;
      ALU_WB:   nxt = FETCH;
      BRANCH:   nxt = FETCH;
      default:  nxt = TRAP;
    endcase
  end

  // ALU function for R-type and multiply-group instructions from the latched fields
  always_comb begin
    shift  = (op_q == OP_R) && (func_q == 6'b000000 || func_q == 6'b000010);
    r_code = (op_q == OP_MUL) ? (func_q == 6'b100001 ? 4'b1011 :
                                 func_q == 6'b100000 ? 4'b1100 : 4'b0010) :
             func_q == 6'b100010 ? 4'b0001 :
             func_q == 6'b100100 ? 4'b0011 :
             func_q == 6'b100101 ? 4'b0100 :
             func_q == 6'b101010 ? 4'b0101 :
             func_q == 6'b000000 ? 4'b1000 :
             func_q == 6'b000010 ? 4'b1001 : 4'b0000;
  end

  // datapath controls; everything held low while reset is asserted
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    PCSrc    = 1'b0;
    RegA     = 1'b0;
    RegB     = 1'b0;
    ALUSrcB  = 2'b00;
    alu      = 4'b0000;
    if (!Rst)
      case (state)
        FETCH:    begin MemRead = 1'b1; ALUSrcB = 2'b01; PCWrite = MemReady; IRWrite = MemReady; end
        DECODE:   ALUSrcB = 2'b11;
        EXEC_R:   begin ALUSrcA = 1'b1; alu = r_code; RegA = shift; RegB = shift; end
        EXEC_I:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; alu = (op_q == OP_ORI) ? 4'b0100 : 4'b0000; end
        MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEM_RD:   MemRead = 1'b1;
        MEM_WB:   RegWrite = 1'b1;
        MEM_WR:   MemWrite = 1'b1;
        ALU_WB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; RegDst = (op_q == OP_R) || (op_q == OP_MUL); end
        BRANCH:   begin ALUSrcA = 1'b1; alu = 4'b0111; PCWrite = !Zero; PCSrc = 1'b1; end
        default:  ;
      endcase
    ALUOp   = ALUOP_W'(alu);
    Illegal = illegal_q & !Rst;
    Fault   = fault_q & !Rst;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random and directed checking of multicycle_controller against an instruction-plan model
module tb_multicycle_controller;
  localparam int TMO = 15;
  localparam int P_FETCH = 0, P_DEC = 1, P_EXR = 2, P_EXI = 3, P_MA = 4, P_MRD = 5;
  localparam int P_MWB = 6, P_MWR = 7, P_AWB = 8, P_BR = 9, P_TRAP = 10;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BNE = 4;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         anyfn;
    int         kind;
    logic [3:0] code;
    bit         sh;
  } ins_t;

  logic Clk = 0, Rst = 1, Zero = 0, MemReady = 0;
  logic [5:0] op = 0, func = 0;
  logic PCWrite, IRWrite, RegDst, RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, PCSrc, RegA, RegB;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic Illegal, Fault;
  logic [18:0] act, exp_v;

  ins_t tbl[$];
  int plan[$];
  int m_ph = P_FETCH, m_wt = 0, m_kind = K_R;
  logic [3:0] m_code = 0;
  bit m_sh = 0, m_ill = 0, m_flt = 0;
  bit p_mr = 0, p_z = 0, p_rst = 1;
  logic [5:0] p_op = 0, p_fn = 0;
  bit chk_en = 0;
  int n_chk = 0, n_pass = 0;

  multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .op(op), .func(func), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .PCSrc(PCSrc), .RegA(RegA), .RegB(RegB), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Illegal(Illegal), .Fault(Fault)
  );

  assign act = {PCWrite, IRWrite, RegDst, RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg,
                PCSrc, RegA, RegB, ALUSrcB, ALUOp, Illegal, Fault};

  always #5 Clk = ~Clk;

  function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == o && (tbl[i].anyfn || tbl[i].fn == f)) return i;
    return -1;
  endfunction

  function automatic logic [18:0] expect_out(input bit mr, input bit z, input bit r);
    logic pcw, irw, rdst, rw, sa, mrd, mw, m2r, pcs, ra, rb;
    logic [1:0] sb;
    logic [3:0] ao;
    {pcw, irw, rdst, rw, sa, mrd, mw, m2r, pcs, ra, rb} = 11'd0;
    sb = 2'd0;
    ao = 4'd0;
    if (r) return 19'd0;
    case (m_ph)
      P_FETCH: begin mrd = 1; sb = 2'd1; pcw = mr; irw = mr; end
      P_DEC:   sb = 2'd3;
      P_EXR:   begin sa = 1; ao = m_code; ra = m_sh; rb = m_sh; end
      P_EXI:   begin sa = 1; sb = 2'd2; ao = m_code; end
      P_MA:    begin sa = 1; sb = 2'd2; end
      P_MRD:   mrd = 1;
      P_MWB:   rw = 1;
      P_MWR:   mw = 1;
      P_AWB:   begin rw = 1; m2r = 1; rdst = (m_kind == K_R); end
      P_BR:    begin sa = 1; ao = 4'd7; pcw = !z; pcs = 1; end
      default: ;
    endcase
    return {pcw, irw, rdst, rw, sa, mrd, mw, m2r, pcs, ra, rb, sb, ao, m_ill, m_flt};
  endfunction

  // move the model one clock edge forward using the inputs of the cycle that just ended
  task automatic advance();
    int k;
    if (p_rst) begin
      m_ph = P_FETCH; m_wt = 0; m_ill = 0; m_flt = 0; plan.delete();
    end else if (m_ph != P_TRAP) begin
      if ((m_ph == P_FETCH || m_ph == P_MRD || m_ph == P_MWR) && !p_mr) begin
        if (m_wt == TMO) begin m_ph = P_TRAP; m_flt = 1; end
        else m_wt++;
      end else begin
        m_wt = 0;
        if (m_ph == P_FETCH) m_ph = P_DEC;
        else if (m_ph == P_DEC) begin
          k = lookup(p_op, p_fn);
          if (k < 0) begin m_ph = P_TRAP; m_ill = 1; end
          else begin
            m_kind = tbl[k].kind; m_code = tbl[k].code; m_sh = tbl[k].sh;
            plan.delete();
            case (m_kind)
              K_R:     begin plan.push_back(P_EXR); plan.push_back(P_AWB); end
              K_I:     begin plan.push_back(P_EXI); plan.push_back(P_AWB); end
              K_LW:    begin plan.push_back(P_MA); plan.push_back(P_MRD); plan.push_back(P_MWB); end
              K_SW:    begin plan.push_back(P_MA); plan.push_back(P_MWR); end
              default: plan.push_back(P_BR);
            endcase
            m_ph = plan.pop_front();
          end
        end else m_ph = (plan.size() > 0) ? plan.pop_front() : P_FETCH;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    advance();
  endtask

  task automatic put(input bit mr, input bit z, input bit r, input logic [5:0] o, input logic [5:0] f);
    MemReady = mr; Zero = z; Rst = r; op = o; func = f;
    p_mr = mr; p_z = z; p_rst = r; p_op = o; p_fn = f;
    exp_v = expect_out(mr, z, r);
    chk_en = 1;
    #5;
  endtask

  task automatic cyc(input bit mr, input bit z, input bit r, input logic [5:0] o, input logic [5:0] f);
    tick();
    put(mr, z, r, o, f);
  endtask

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, a, e);
  endtask

  // every cycle: whole output vector against the model
  always @(negedge Clk)
    if (chk_en) begin
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL cycle t=%0t phase=%0d rst=%0b got=%b want=%b", $time, m_ph, Rst, act, exp_v);
    end

  initial begin
    int burst;
    bit mr, r;
    logic [5:0] o, f;
    ins_t t;
    tbl.push_back('{6'd0,  6'd32, 0, K_R,   4'd0, 0});
    tbl.push_back('{6'd0,  6'd34, 0, K_R,   4'd1, 0});
    tbl.push_back('{6'd0,  6'd36, 0, K_R,   4'd3, 0});
    tbl.push_back('{6'd0,  6'd37, 0, K_R,   4'd4, 0});
    tbl.push_back('{6'd0,  6'd42, 0, K_R,   4'd5, 0});
    tbl.push_back('{6'd0,  6'd0,  0, K_R,   4'd8, 1});
    tbl.push_back('{6'd0,  6'd2,  0, K_R,   4'd9, 1});
    tbl.push_back('{6'd8,  6'd0,  1, K_I,   4'd0, 0});
    tbl.push_back('{6'd13, 6'd0,  1, K_I,   4'd4, 0});
    tbl.push_back('{6'd35, 6'd0,  1, K_LW,  4'd0, 0});
    tbl.push_back('{6'd43, 6'd0,  1, K_SW,  4'd0, 0});
    tbl.push_back('{6'd5,  6'd0,  1, K_BNE, 4'd0, 0});
`ifdef CTRL_MUL_EN
    tbl.push_back('{6'd28, 6'd33, 0, K_R, 4'd11, 0});
    tbl.push_back('{6'd28, 6'd32, 0, K_R, 4'd12, 0});
    tbl.push_back('{6'd28, 6'd2,  0, K_R, 4'd2,  0});
`endif
    cyc(1, 0, 1, 6'd0, 6'd0);
    cyc(1, 1, 1, 6'd35, 6'd9);
    chk("reset_all_zero", int'(act), 0);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("add_fetch_irw_pcw", {IRWrite, PCWrite}, 3);
    cyc(1, 0, 0, 6'd0, 6'd32);
    chk("add_decode_srcb", ALUSrcB, 3);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("add_exec_aluop", ALUOp, 0);
    chk("add_exec_srca", ALUSrcA, 1);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("add_wb_rw_rdst_m2r", {RegWrite, RegDst, MemtoReg}, 7);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("add_len4_fetch", {MemRead, ALUSrcB}, 5);
    cyc(1, 0, 0, 6'd35, 6'($urandom));
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 6'($urandom), 6'($urandom));
      chk("lw_wait_memread", {MemRead, RegWrite}, 2);
    end
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("lw_ready_memread", MemRead, 1);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("lw_wb_rw_m2r_rdst", {RegWrite, MemtoReg, RegDst}, 4);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("lw_len8_fetch", {MemRead, ALUSrcB}, 5);
    cyc(1, 0, 0, 6'd5, 6'($urandom));
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("bne_z0_pcw_pcs", {PCWrite, PCSrc}, 3);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("bne_z0_back_fetch", ALUSrcB, 1);
    cyc(1, 0, 0, 6'd5, 6'($urandom));
    cyc(1, 1, 0, 6'($urandom), 6'($urandom));
    chk("bne_z1_pcw_pcs", {PCWrite, PCSrc}, 1);
    cyc(0, 0, 0, 6'($urandom), 6'($urandom));
    chk("bne_z1_back_fetch", ALUSrcB, 1);
    cyc(0, 0, 1, 6'd0, 6'd0);
    for (int i = 0; i < TMO + 1; i++) cyc(0, 0, 0, 6'($urandom), 6'($urandom));
    chk("tmo_last_wait_no_fault", {Fault, MemRead}, 1);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("tmo_trap_fault", Fault, 1);
    chk("tmo_trap_quiet", {IRWrite, MemRead}, 0);
    cyc(0, 0, 1, 6'd0, 6'd0);
    for (int i = 0; i < TMO; i++) cyc(0, 0, 0, 6'($urandom), 6'($urandom));
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("tmo_edge_irwrite", IRWrite, 1);
    cyc(1, 0, 0, 6'd28, 6'd33);
    chk("tmo_edge_decode", {Fault, ALUSrcB}, 3);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
`ifdef CTRL_MUL_EN
    chk("mul_exec_aluop", ALUOp, 11);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("mul_wb_rw_rdst", {RegWrite, RegDst, Illegal}, 6);
`else
    chk("mul_off_illegal", Illegal, 1);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    chk("mul_off_no_write", {RegWrite, Illegal}, 1);
`endif
    cyc(0, 0, 1, 6'd0, 6'd0);
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    cyc(1, 0, 0, 6'd43, 6'($urandom));
    cyc(1, 0, 0, 6'($urandom), 6'($urandom));
    cyc(0, 0, 0, 6'($urandom), 6'($urandom));
    chk("sw_wait_memwrite", {MemWrite, RegWrite}, 2);
    cyc(1, 0, 1, 6'($urandom), 6'($urandom));
    chk("sw_rst_all_zero", int'(act), 0);
    cyc(0, 0, 0, 6'($urandom), 6'($urandom));
    chk("sw_rst_fetch", {MemRead, ALUSrcB, MemWrite}, 10);
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      r = (m_ph == P_TRAP && $urandom % 6 == 0) || ($urandom % 400 == 0);
      if (burst > 0) begin
        mr = 0;
        burst--;
      end else begin
        if ($urandom % 150 == 0) burst = $urandom_range(12, 20);
        mr = ($urandom % 4 != 0);
      end
      o = 6'($urandom);
      f = 6'($urandom);
      if (m_ph == P_DEC && $urandom % 10 != 0) begin
        t = tbl[$urandom_range(0, tbl.size() - 1)];
        o = t.op;
        if (!t.anyfn) f = t.fn;
      end
      put(mr, 1'($urandom), r, o, f);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
